display7_scan: RTL and testbench

//  Time-multiplexed scan driver for a multi-digit 7-segment display; sits directly upstream of display7.

---
 rtl/display7_pkg.sv | 13 +
 rtl/display7_scan_if.sv | 17 +
 rtl/display7_scan_prescaler.sv | 29 ++
 rtl/display7_scan.sv | 107 ++++++++++
 tb/tb_display7_scan.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/display7_pkg.sv
// Shared constants and helpers for the 7-segment display path (display7, display7_scan).
package display7_pkg;

  localparam int   NIBBLE_W   = 4;
  localparam int   SEG_W      = 7;
  localparam logic SEL_ACTIVE = 1'b0;  // board anodes are driven low to light a digit

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/display7_scan_if.sv
// Display word in, scanned digit/select/frame out, for display7_scan.
interface display7_scan_if
  import display7_pkg::*;
#(
  parameter int NUM_DIGITS = 8
);

  logic [NIBBLE_W*NUM_DIGITS-1:0] iData;
  logic                           iEn;
  logic [NIBBLE_W-1:0]            oDigit;
  logic [NUM_DIGITS-1:0]          oSel;
  logic                           oFrame;

  modport master (output iData, iEn, input oDigit, oSel, oFrame);
  modport slave  (input iData, iEn, output oDigit, oSel, oFrame);

endinterface

// File: rtl/display7_scan_prescaler.sv
// Digit-rate prescaler: counts 0..DIV-1 and flags the last count with oTick.
module scan_prescaler
  import display7_pkg::*;
#(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic oTick
);

  localparam int               CNT_W    = width_of(DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Explicit compare keeps non-power-of-two moduli exact.
  always_comb begin
    oTick = (cnt_q == CNT_LAST);
    cnt_d = oTick ? '0 : cnt_q + CNT_W'(1);
  end

  // NOTE: state updates use <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display7_scan.sv
// Time-multiplexed 7-segment scan driver with per-frame snapshot of the display word.
// Define DISPLAY7_SCAN_LZB_EN to enable leading-zero blanking.
module display7_scan
  import display7_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 100000
) (
  input logic             clk,
  input logic             reset,
  display7_scan_if.slave  bus
);

  localparam int               IDX_W    = width_of(NUM_DIGITS);
  localparam int               DATA_W   = NIBBLE_W * NUM_DIGITS;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{~SEL_ACTIVE}};

  logic                  tick;
  logic                  reload;
  logic [IDX_W-1:0]      idx_q,    idx_d;
  logic [DATA_W-1:0]     shadow_q, shadow_d;
  logic [NIBBLE_W-1:0]   digit_q,  digit_d;
  logic [NUM_DIGITS-1:0] sel_q,    sel_d;
  logic                  frame_q,  frame_d;
  logic [NUM_DIGITS-1:0] blank_d;

  scan_prescaler #(.DIV(SCAN_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .oTick (tick)
  );

  // Select pattern for one digit; blanked digits stay inactive.
  function automatic logic [NUM_DIGITS-1:0] sel_for(input logic [IDX_W-1:0]      idx,
                                                     input logic [NUM_DIGITS-1:0] blank);
    logic [NUM_DIGITS-1:0] sel;
    sel = SEL_OFF;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IDX_W'(k) && !blank[k]) sel[k] = SEL_ACTIVE;
    end
    return sel;
  endfunction

`ifdef DISPLAY7_SCAN_LZB_EN
  // Blank every digit above the most significant non-zero nibble; digit 0 always lit.
  function automatic logic [NUM_DIGITS-1:0] lzb_mask(input logic [DATA_W-1:0] word);
    logic [NUM_DIGITS-1:0] mask;
    logic                  seen;
    mask = '0;
    seen = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      seen    = seen | (word[NIBBLE_W*k +: NIBBLE_W] != '0);
      mask[k] = ~seen;
    end
    return mask;
  endfunction

  logic [NUM_DIGITS-1:0] blank_q;

  always_comb blank_d = reload ? lzb_mask(bus.iData) : blank_q;

  // The mask tracks the shadow, so it resets to the mask of an all-zero word.
  always_ff @(posedge clk) begin
    if (reset) blank_q <= lzb_mask('0);
    else       blank_q <= blank_d;
  end
`else
  always_comb blank_d = '0;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    reload   = tick && (idx_q == IDX_LAST);
    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (tick) idx_d = reload ? '0 : idx_q + IDX_W'(1);
    if (reload) shadow_d = bus.iData;

    // Outputs follow next-state values so they move on the same edge as idx.
    digit_d = shadow_d[NIBBLE_W*idx_d +: NIBBLE_W];
    sel_d   = bus.iEn ? sel_for(idx_d, blank_d) : SEL_OFF;
    frame_d = reload;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q    <= '0;
      shadow_q <= '0;
      digit_q  <= '0;
      sel_q    <= SEL_OFF;
      frame_q  <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      digit_q  <= digit_d;
      sel_q    <= sel_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.oDigit = digit_q;
  assign bus.oSel   = sel_q;
  assign bus.oFrame = frame_q;

endmodule

// File: tb/tb_display7_scan.sv
// Directed bench for display7_scan with NUM_DIGITS=4, SCAN_DIV=4; edges counted from reset release.
module tb_display7_scan;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_fails  = 0;

  display7_scan_if #(.NUM_DIGITS(4)) bus ();

  display7_scan #(.NUM_DIGITS(4), .SCAN_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] sel, input logic [3:0] digit,
                           input logic frame);
    check({tag, ".sel"},   32'(bus.oSel),   32'(sel));
    check({tag, ".digit"}, 32'(bus.oDigit), 32'(digit));
    check({tag, ".frame"}, 32'(bus.oFrame), 32'(frame));
  endtask

  initial begin
    bus.iData = 16'h0000;
    bus.iEn   = 1'b1;

    // Reset held for three edges
    step(3);
    check_out("reset", 4'b1111, 4'h0, 1'b0);
    reset     = 1'b0;
    bus.iData = 16'h4321;

    step(1);   // E1: digit 0, first frame shows zeros
    check_out("e1", 4'b1110, 4'h0, 1'b0);
    step(14);  // E15
    check_out("e15", 4'b0111, 4'h0, 1'b0);
    step(1);   // E16: first snapshot
    check_out("e16", 4'b1110, 4'h1, 1'b1);
    step(1);   // E17
    check_out("e17", 4'b1110, 4'h1, 1'b0);
    step(3);   // E20
    check_out("e20", 4'b1101, 4'h2, 1'b0);
    step(4);   // E24
    check_out("e24", 4'b1011, 4'h3, 1'b0);
    step(4);   // E28
    check_out("e28", 4'b0111, 4'h4, 1'b0);
    step(4);   // E32
    check_out("e32", 4'b1110, 4'h1, 1'b1);

    // Mid-frame data change must not tear the frame
    step(9);   // E41, idx=2
    bus.iData = 16'hABCD;
    step(3);   // E44
    check_out("e44", 4'b0111, 4'h4, 1'b0);
    step(4);   // E48
    check_out("e48", 4'b1110, 4'hD, 1'b1);
    step(4);   // E52
    check_out("e52", 4'b1101, 4'hC, 1'b0);
    step(4);   // E56
    check_out("e56", 4'b1011, 4'hB, 1'b0);
    step(4);   // E60
    check_out("e60", 4'b0111, 4'hA, 1'b0);

    // Display disable while the scan keeps running
    step(8);   // E68, idx=1
    bus.iEn = 1'b0;
    step(1);   // E69
    check_out("e69", 4'b1111, 4'hC, 1'b0);
    step(3);   // E72
    check_out("e72", 4'b1111, 4'hB, 1'b0);
    step(4);   // E76, idx=3
    check_out("e76", 4'b1111, 4'hA, 1'b0);
    bus.iEn = 1'b1;
    step(1);   // E77
    check_out("e77", 4'b0111, 4'hA, 1'b0);
    step(3);   // E80
    check_out("e80", 4'b1110, 4'hD, 1'b1);

    // Reset mid-frame
    step(8);   // E88, idx=2
    check_out("e88", 4'b1011, 4'hB, 1'b0);
    reset = 1'b1;
    step(1);   // E89
    check_out("rst_mid", 4'b1111, 4'h0, 1'b0);
    reset = 1'b0;
    step(1);   // F1
    check_out("f1", 4'b1110, 4'h0, 1'b0);
    step(14);  // F15
    check_out("f15", 4'b0111, 4'h0, 1'b0);
    step(1);   // F16
    check_out("f16", 4'b1110, 4'hD, 1'b1);

    // Leading-zero blanking (or all lit without the macro)
    bus.iData = 16'h0050;
    step(16);  // F32
    check_out("f32", 4'b1110, 4'h0, 1'b1);
    step(4);   // F36
    check_out("f36", 4'b1101, 4'h5, 1'b0);
`ifdef DISPLAY7_SCAN_LZB_EN
    step(4);   // F40
    check_out("f40", 4'b1111, 4'h0, 1'b0);
    step(4);   // F44
    check_out("f44", 4'b1111, 4'h0, 1'b0);
`else
    step(4);   // F40
    check_out("f40", 4'b1011, 4'h0, 1'b0);
    step(4);   // F44
    check_out("f44", 4'b0111, 4'h0, 1'b0);
`endif
    bus.iData = 16'h0000;
    step(4);   // F48
    check_out("f48", 4'b1110, 4'h0, 1'b1);
    step(4);   // F52
`ifdef DISPLAY7_SCAN_LZB_EN
    check_out("f52", 4'b1111, 4'h0, 1'b0);
`else
    check_out("f52", 4'b1101, 4'h0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
